issue_bus_arbiter: RTL

//   Multi-channel issue stage. SRC_COUNT reservation stations present issue packets.
//   Up to BUS_COUNT are granted per cycle, registered, and driven onto BUS_COUNT

---
 rtl/issue_bus_arbiter_pkg.sv | 61 ++++++
 rtl/issue_bus_arbiter_if.sv | 29 ++
 rtl/issue_bus_arbiter_rr_grant_select.sv | 48 ++++
 rtl/issue_bus_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/issue_bus_arbiter_pkg.sv
// Shared types for the multi-channel issue stage: packet layout, its cleared
// value, and the instruction enums that the execution combos and ROB decode.
package issue_bus_arbiter_pkg;

   localparam int XLEN  = 32;
   localparam int REG_W = 5;

   typedef enum logic [3:0] {
      UNKNOWN = 4'd0,
      ADD     = 4'd1,
      SUB     = 4'd2,
      LOAD    = 4'd3,
      STORE   = 4'd4,
      BEQ     = 4'd5,
      JAL     = 4'd6,
      MUL     = 4'd7
   } instr_name_e;

   typedef enum logic [2:0] {
      XX     = 3'd0,
      ALU    = 3'd1,
      MEM    = 3'd2,
      BRANCH = 3'd3,
      MULDIV = 3'd4
   } instr_type_e;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
   } registers_t;

   typedef logic [3:0] flag_vector_t;

   typedef struct packed {
      logic [XLEN-1:0] address;
      logic [XLEN-1:0] immediate;
      logic [XLEN-1:0] data_1;
      logic [XLEN-1:0] data_2;
      logic            valid_1;
      logic            valid_2;
      instr_name_e     instr_name;
      instr_type_e     instr_type;
      registers_t      regs;
      flag_vector_t    flags;
   } issue_pkt_t;

   localparam issue_pkt_t ISSUE_PKT_CLEAR = '{
      address:    '0,
      immediate:  '0,
      data_1:     '0,
      data_2:     '0,
      valid_1:    1'b0,
      valid_2:    1'b0,
      instr_name: UNKNOWN,
      instr_type: XX,
      regs:       '0,
      flags:      '0
   };

endpackage

// File: rtl/issue_bus_arbiter_if.sv
// Request side (stations) and bus side (execution combos / ROB) of the issue stage.
// master: the arbiter; slave: the stations and bus consumers around it.
interface issue_bus_arbiter_if #(
   parameter int SRC_COUNT = 4,
   parameter int BUS_COUNT = 2
);
   import issue_bus_arbiter_pkg::*;

   localparam int CNT_W = $clog2(BUS_COUNT + 1);

   logic [SRC_COUNT-1:0] req_valid;
   issue_pkt_t           req_pkt [SRC_COUNT];
   logic [SRC_COUNT-1:0] req_grant;
   logic [BUS_COUNT-1:0] bus_valid;
   issue_pkt_t           bus_pkt [BUS_COUNT];
   logic [BUS_COUNT-1:0] bus_ready;
   logic [CNT_W-1:0]     issue_count;

   modport master (
      input  req_valid, req_pkt, bus_ready,
      output req_grant, bus_valid, bus_pkt, issue_count
   );

   modport slave (
      output req_valid, req_pkt, bus_ready,
      input  req_grant, bus_valid, bus_pkt, issue_count
   );

endinterface

// File: rtl/issue_bus_arbiter_rr_grant_select.sv
// N-way priority encoder that starts its scan at ptr and wraps, returning the
// first min(limit, M) requesting indices in scan order plus a one-hot-per-winner
// grant vector. Generic so other arbiters can reuse it.
module rr_grant_select #(
   parameter int N     = 4,
   parameter int M     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1,
   parameter int CNT_W = $clog2(M + 1)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic [CNT_W-1:0] limit,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] sel_idx [M],
   output logic [CNT_W-1:0] sel_cnt
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] pos;

   // walk requesters in rotated order and keep the winners in the order found
   always_comb begin
      sum     = '0;
      pos     = '0;
      grant   = '0;
      sel_cnt = '0;
      for (int m = 0; m < M; m++) begin
         sel_idx[m] = '0;
      end
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (sum >= (IDX_W + 1)'(N)) begin
            sum = sum - (IDX_W + 1)'(N);
         end
         pos = sum[IDX_W-1:0];
         if (req[pos] && (sel_cnt < limit) && (sel_cnt < CNT_W'(M))) begin
            grant[pos] = 1'b1;
            for (int m = 0; m < M; m++) begin
               if (CNT_W'(m) == sel_cnt) begin
                  sel_idx[m] = pos;
               end
            end
            sel_cnt = sel_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/issue_bus_arbiter.sv
// Multi-channel issue stage. Each cycle the stations that win arbitration are
// paired with free output buses (k-th winner -> k-th lowest free bus) and their
// packets are registered onto those buses for the following cycle.
module issue_bus_arbiter
   import issue_bus_arbiter_pkg::*;
#(
   parameter int SRC_COUNT = 4,
   parameter int BUS_COUNT = 2,
   parameter int RR_EN     = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   issue_bus_arbiter_if.master bus
);

   localparam int PTR_W = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;
   localparam int CNT_W = $clog2(BUS_COUNT + 1);

   logic                 block_issue;
   logic [SRC_COUNT-1:0] req_live;
   logic [BUS_COUNT-1:0] bus_free;
   logic [CNT_W-1:0]     free_cnt;
   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     rr_ptr_nxt;
   logic [PTR_W-1:0]     scan_ptr;
   logic [SRC_COUNT-1:0] grant;
   logic [PTR_W-1:0]     sel_idx [BUS_COUNT];
   logic [CNT_W-1:0]     sel_cnt;
   logic [CNT_W-1:0]     slot;
   logic [BUS_COUNT-1:0] load;
   logic [PTR_W-1:0]     load_src [BUS_COUNT];
   logic [BUS_COUNT-1:0] bus_valid_q;
   issue_pkt_t           bus_pkt_q [BUS_COUNT];

   // a bus can accept a new packet when it is empty or its current one leaves now;
   // reset and flush suppress every request so nothing is granted or captured
   always_comb begin
      block_issue = reset | flush;
      req_live    = block_issue ? '0 : bus.req_valid;
      scan_ptr    = (RR_EN != 0) ? rr_ptr : '0;
      bus_free    = ~bus_valid_q | bus.bus_ready;
      free_cnt    = '0;
      for (int b = 0; b < BUS_COUNT; b++) begin
         free_cnt = free_cnt + CNT_W'(bus_free[b]);
      end
   end

   rr_grant_select #(
      .N     (SRC_COUNT),
      .M     (BUS_COUNT),
      .IDX_W (PTR_W),
      .CNT_W (CNT_W)
   ) u_sel (
      .req     (req_live),
      .ptr     (scan_ptr),
      .limit   (free_cnt),
      .grant   (grant),
      .sel_idx (sel_idx),
      .sel_cnt (sel_cnt)
   );

   // pair the winners, in priority order, with free buses in ascending index order
   always_comb begin
      slot = '0;
      load = '0;
      for (int b = 0; b < BUS_COUNT; b++) begin
         load_src[b] = '0;
      end
      for (int b = 0; b < BUS_COUNT; b++) begin
         if (bus_free[b]) begin
            for (int m = 0; m < BUS_COUNT; m++) begin
               if ((CNT_W'(m) == slot) && (slot < sel_cnt)) begin
                  load[b]     = 1'b1;
                  load_src[b] = sel_idx[m];
               end
            end
            slot = slot + CNT_W'(1);
         end
      end
   end

   // next scan start is just past the lowest-priority winner of this cycle
   always_comb begin
      rr_ptr_nxt = rr_ptr;
      if (RR_EN == 0) begin
         rr_ptr_nxt = '0;
      end else if (sel_cnt != '0) begin
         for (int m = 0; m < BUS_COUNT; m++) begin
            if (CNT_W'(m) == (sel_cnt - CNT_W'(1))) begin
               rr_ptr_nxt = (sel_idx[m] == PTR_W'(SRC_COUNT - 1)) ? '0 : sel_idx[m] + PTR_W'(1);
            end
         end
      end
   end

   // output bus registers and priority pointer; a full bus not taken holds its packet
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
         for (int b = 0; b < BUS_COUNT; b++) begin
            bus_valid_q[b] <= 1'b0;
            bus_pkt_q[b]   <= ISSUE_PKT_CLEAR;
         end
      end else begin
         rr_ptr <= rr_ptr_nxt;
         for (int b = 0; b < BUS_COUNT; b++) begin
            if (flush) begin
               bus_valid_q[b] <= 1'b0;
               bus_pkt_q[b]   <= ISSUE_PKT_CLEAR;
            end else if (bus_free[b]) begin
               bus_valid_q[b] <= load[b];
               bus_pkt_q[b]   <= load[b] ? bus.req_pkt[load_src[b]] : ISSUE_PKT_CLEAR;
            end
         end
      end
   end

   assign bus.req_grant   = grant;
   assign bus.issue_count = sel_cnt;
   assign bus.bus_valid   = bus_valid_q;
   assign bus.bus_pkt     = bus_pkt_q;

endmodule
